// File: rtl/fbindct_pkg.sv
// Shared widths, FSM state type and row-result narrowing for the 8x8 binDCT controller.
// Narrowing saturates when FBINDCT_ROW_SAT_EN is defined, otherwise wraps.
package fbindct_pkg;

  localparam int unsigned IN_W_DEF  = 8;
  localparam int unsigned MID_W_DEF = 12;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned N_PT      = 8;

  typedef enum logic [1:0] {
    S_ROW     = 2'd0,
    S_COL_LD  = 2'd1,
    S_COL_OUT = 2'd2
  } state_e;

  // Reduce a sign-extended row-pass result to a w-bit signed value (returned sign-extended).
  function automatic logic signed [31:0] narrow(input logic signed [31:0] x, input int unsigned w);
`ifdef FBINDCT_ROW_SAT_EN
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'd1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
`else
    return (x <<< (32'd32 - w)) >>> (32'd32 - w);
`endif
  endfunction

endpackage

// File: rtl/fbindct_tbuf.sv
// 8x8 transpose buffer: whole-row write port, combinational whole-column read port.
// Lane k of a packed vector sits at bits [k*MID_W +: MID_W]; storage is not reset.
module fbindct_tbuf
  import fbindct_pkg::*;
#(
  parameter int unsigned MID_W = MID_W_DEF
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [2:0]             wr_row,
  input  logic [8*MID_W-1:0]     wr_data,
  input  logic [2:0]             rd_col,
  output logic [8*MID_W-1:0]     rd_data
);

  logic [MID_W-1:0] mem_q [N_PT][N_PT];
  logic [MID_W-1:0] mem_d [N_PT][N_PT];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int k = 0; k < int'(N_PT); k++) begin
        mem_d[wr_row][k] = wr_data[k*MID_W +: MID_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Column read: lane r is row r of the selected column.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < int'(N_PT); r++) begin
      rd_data[r*MID_W +: MID_W] = mem_q[r][rd_col];
    end
  end

endmodule

// File: rtl/fbindct_2d_ctrl.sv
// 8x8 2D forward binDCT sequencer around a shared external 1D core: row pass, transpose, column pass.
// Build option FBINDCT_ROW_SAT_EN selects saturating (vs wrapping) row-result narrowing.
module fbindct_2d_ctrl
  import fbindct_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned MID_W = MID_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*IN_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data,
  output logic [2:0]           out_col,
  output logic [8*MID_W-1:0]   core_x_in,
  input  logic [8*OUT_W-1:0]   core_x_out,
  output logic                 busy,
  output logic                 block_done
);

  state_e               state_q, state_d;
  logic [2:0]           row_cnt_q, row_cnt_d;
  logic [2:0]           col_cnt_q, col_cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [8*OUT_W-1:0]   out_data_q, out_data_d;
  logic [2:0]           out_col_q, out_col_d;
  logic                 busy_q, busy_d;
  logic                 block_done_q, block_done_d;

  logic                 wr_en;
  logic [8*MID_W-1:0]   wr_data;
  logic [8*MID_W-1:0]   rd_data;

  fbindct_tbuf #(.MID_W(MID_W)) u_tbuf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_row  (row_cnt_q),
    .wr_data (wr_data),
    .rd_col  (col_cnt_q),
    .rd_data (rd_data)
  );

  // Row-pass core results narrowed into the transpose buffer width.
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < int'(N_PT); k++) begin
      wr_data[k*MID_W +: MID_W] =
        MID_W'(narrow(32'(signed'(core_x_out[k*OUT_W +: OUT_W])), MID_W));
    end
  end

  // Core input: sign-extended pixels during row pass, buffered column otherwise.
  always_comb begin
    core_x_in = rd_data;
    if (state_q == S_ROW) begin
      for (int k = 0; k < int'(N_PT); k++) begin
        core_x_in[k*MID_W +: MID_W] = MID_W'(signed'(in_data[k*IN_W +: IN_W]));
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_col_d    = out_col_q;
    busy_d       = busy_q;
    block_done_d = 1'b0;
    wr_en        = 1'b0;

    case (state_q)
      S_ROW: begin
        if (in_valid && in_ready_q) begin
          wr_en  = 1'b1;
          busy_d = 1'b1;
          if (row_cnt_q == 3'd7) begin
            row_cnt_d  = 3'd0;
            in_ready_d = 1'b0;
            state_d    = S_COL_LD;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end
      end
      S_COL_LD: begin
        out_data_d  = core_x_out;
        out_col_d   = col_cnt_q;
        out_valid_d = 1'b1;
        state_d     = S_COL_OUT;
      end
      S_COL_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (col_cnt_q == 3'd7) begin
            col_cnt_d    = 3'd0;
            busy_d       = 1'b0;
            block_done_d = 1'b1;
            in_ready_d   = 1'b1;
            state_d      = S_ROW;
          end else begin
            col_cnt_d = col_cnt_q + 3'd1;
            state_d   = S_COL_LD;
          end
        end
      end
      default: begin
        state_d     = S_ROW;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ROW;
      row_cnt_q    <= 3'd0;
      col_cnt_q    <= 3'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_col_q    <= 3'd0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_cnt_q    <= col_cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_col_q    <= out_col_d;
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_col    = out_col_q;
  assign busy       = busy_q;
  assign block_done = block_done_q;

endmodule
